// File: rtl/acl_dmem_arbiter_pkg.sv
// Shared types and status-word layout for the accelerometer / CPU data-RAM arbiter.
package acl_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FORCE   = 2'd2
    } state_e;

    localparam int PTR_W       = 6;
    localparam int CNT_W       = 7;
    localparam int STS_OVF_BIT = 31;
    localparam int STS_CNT_LSB = 16;
    localparam int STS_PTR_LSB = 0;

    function automatic logic [31:0] make_status(input logic             ovf,
                                                input logic [CNT_W-1:0] cnt,
                                                input logic [PTR_W-1:0] ptr);
        logic [31:0] w;
        w                          = '0;
        w[STS_OVF_BIT]             = ovf;
        w[STS_CNT_LSB +: CNT_W]    = cnt;
        w[STS_PTR_LSB +: PTR_W]    = ptr;
        return w;
    endfunction

endpackage

// File: rtl/acl_ring_ptr.sv
// Ring-buffer write pointer plus saturating fill count and sticky overflow flag.
module acl_ring_ptr
    import acl_dmem_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit,
    input  logic             clr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (commit) begin
            ptr_d = (ptr_q + 1'b1) & PTR_MASK;
            // A full ring keeps its count; the write overwrites the oldest entry.
            if (cnt_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign wr_ptr   = ptr_q;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/acl_dmem_arbiter.sv
// Shares the data-RAM port between the CPU (priority) and accelerometer samples,
// with a bounded-wait stall so samples always land in the RAM ring buffer.
module acl_dmem_arbiter
    import acl_dmem_arbiter_pkg::*;
#(
    parameter logic [11:0] BUF_BASE    = 12'hF00,
    parameter int          BUF_DEPTH   = 64,
    parameter int          MAX_WAIT    = 8,
    parameter logic [11:0] STATUS_ADDR = 12'hFFF,
    parameter logic [11:0] CLR_ADDR    = 12'hFFE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wren,
    input  logic [11:0] cpu_addr,
    input  logic [31:0] cpu_data,
    output logic [31:0] cpu_q,
    output logic        cpu_stall,
    input  logic        acl_valid,
    input  logic [14:0] acl_data,
    output logic        acl_ready,
    output logic        ram_wen,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    localparam int WAIT_W = $clog2(MAX_WAIT) + 1;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       hold_q, hold_d;
    logic              status_rd_q, status_rd_d;
    logic [31:0]       status_q, status_d;
    logic              commit, clr, cpu_owns;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    acl_ring_ptr #(.BUF_DEPTH(BUF_DEPTH)) u_ring (
        .clock    (clock),
        .reset    (reset),
        .commit   (commit),
        .clr      (clr),
        .wr_ptr   (wr_ptr),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        hold_d    = hold_q;
        commit    = 1'b0;
        cpu_owns  = 1'b1;
        acl_ready = 1'b0;
        cpu_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                acl_ready = 1'b1;
                if (acl_valid) begin
                    hold_d  = {17'b0, acl_data};
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (!cpu_req) begin
                    commit   = 1'b1;
                    cpu_owns = 1'b0;
                    state_d  = ST_IDLE;
                end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    state_d = ST_FORCE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_FORCE: begin
                cpu_stall = 1'b1;
                commit    = 1'b1;
                cpu_owns  = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ram_addr    = cpu_addr;
        ram_din     = cpu_data;
        ram_wen     = cpu_req & cpu_wren;
        clr         = 1'b0;
        status_rd_d = 1'b0;
        if (!cpu_owns) begin
            ram_addr = BUF_BASE + 12'(wr_ptr);
            ram_din  = hold_q;
            ram_wen  = 1'b1;
        end else begin
            // MMIO addresses shadow RAM: stores there never reach the array.
            if (cpu_addr == STATUS_ADDR || cpu_addr == CLR_ADDR) begin
                ram_wen = 1'b0;
            end
            clr         = cpu_req & cpu_wren & (cpu_addr == CLR_ADDR);
            status_rd_d = cpu_req & ~cpu_wren & (cpu_addr == STATUS_ADDR);
        end

        if (!reset) begin
            acl_ready = 1'b0;
            cpu_stall = 1'b0;
            ram_wen   = 1'b0;
            commit    = 1'b0;
            clr       = 1'b0;
        end
    end

    assign status_d = make_status(overflow, count, wr_ptr);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            hold_q      <= '0;
            status_rd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            hold_q      <= hold_d;
            status_rd_q <= status_rd_d;
        end
    end

    // Status is captured with the request so it lines up with the RAM's read latency.
    always_ff @(posedge clock) begin
        status_q <= status_d;
    end

    assign cpu_q = status_rd_q ? status_q : ram_dout;

endmodule

// File: tb/tb_acl_dmem_arbiter.sv
// Directed bench for acl_dmem_arbiter: reset, idle/busy CPU, MMIO, overflow, back-to-back samples.
module tb_acl_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_wren;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_data;
    logic [31:0] cpu_q;
    logic        cpu_stall;
    logic        acl_valid;
    logic [14:0] acl_data;
    logic        acl_ready;
    logic        ram_wen;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    acl_dmem_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_wren  (cpu_wren),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_q     (cpu_q),
        .cpu_stall (cpu_stall),
        .acl_valid (acl_valid),
        .acl_data  (acl_data),
        .acl_ready (acl_ready),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        cpu_req   = 1'b0;
        cpu_wren  = 1'b0;
        cpu_addr  = 12'h000;
        cpu_data  = 32'h0;
        acl_valid = 1'b0;
        acl_data  = 15'h0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        ram_dout = 32'h0;
        idle();
        tick();
        tick();

        // reset held low: outputs forced inactive even with requests present
        acl_valid = 1'b1; cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h010; cpu_data = 32'h1;
        settle();
        chk("rst_outputs", 64'({acl_ready, cpu_stall, ram_wen}), 64'(3'b000));
        tick();
        reset = 1'b1; idle(); cpu_req = 1'b1; cpu_addr = 12'hFFF;
        settle();
        chk("rst_release_ready", 64'(acl_ready), 64'(1'b1));
        tick(); idle(); settle();
        chk("rst_status", 64'(cpu_q), 64'(32'h0));

        // idle CPU: single sample
        tick(); idle(); acl_valid = 1'b1; acl_data = 15'h1234;
        settle();
        chk("idle_ready", 64'(acl_ready), 64'(1'b1));
        tick(); idle(); settle();
        chk("idle_write", 64'({ram_wen, ram_addr, ram_din}), 64'({1'b1, 12'hF00, 32'h00001234}));
        chk("idle_pend_ready", 64'(acl_ready), 64'(1'b0));
        tick(); idle(); cpu_req = 1'b1; cpu_addr = 12'hFFF;
        settle();
        chk("sts_read_nowen", 64'(ram_wen), 64'(1'b0));
        tick(); idle(); ram_dout = 32'hDEADBEEF; settle();
        chk("sts_one", 64'(cpu_q), 64'(32'h00010001));
        tick(); idle(); settle();
        chk("cpu_q_from_ram", 64'(cpu_q), 64'(32'hDEADBEEF));

        // busy CPU: forced write in the ninth cycle after accept
        tick(); idle(); acl_valid = 1'b1; acl_data = 15'h0ABC; cpu_req = 1'b1; cpu_addr = 12'h020;
        for (int k = 1; k <= 8; k++) begin
            tick(); acl_valid = 1'b1; acl_data = 15'h7FFF; cpu_req = 1'b1; cpu_addr = 12'h020;
            settle();
            chk("busy_wait", 64'({cpu_stall, ram_wen, acl_ready, ram_addr}), 64'({3'b000, 12'h020}));
        end
        tick(); settle();
        chk("busy_force", 64'({cpu_stall, ram_wen, ram_addr, ram_din}),
            64'({1'b1, 1'b1, 12'hF01, 32'h00000ABC}));
        tick(); acl_valid = 1'b0; settle();
        chk("busy_after", 64'({cpu_stall, acl_ready}), 64'(2'b01));
        tick(); idle(); cpu_req = 1'b1; cpu_addr = 12'hFFF;
        tick(); idle(); settle();
        chk("sts_busy", 64'(cpu_q), 64'(32'h00020002));

        // MMIO protection and clear
        tick(); idle(); cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'hFFF; cpu_data = 32'h55;
        settle();
        chk("mmio_sts_store", 64'(ram_wen), 64'(1'b0));
        tick(); cpu_addr = 12'hFFE; settle();
        chk("mmio_clr_store", 64'(ram_wen), 64'(1'b0));
        tick(); cpu_addr = 12'h010; cpu_data = 32'hCAFEF00D; settle();
        chk("plain_store", 64'({ram_wen, ram_addr, ram_din}), 64'({1'b1, 12'h010, 32'hCAFEF00D}));
        tick(); idle(); cpu_req = 1'b1; cpu_addr = 12'hFFF;
        tick(); idle(); settle();
        chk("sts_after_clr", 64'(cpu_q), 64'(32'h00000002));

        // reset during PENDING discards the sample
        tick(); idle(); acl_valid = 1'b1; acl_data = 15'h1111; cpu_req = 1'b1; cpu_addr = 12'h030;
        tick(); acl_valid = 1'b0; settle();
        chk("pend_hold", 64'({ram_wen, acl_ready}), 64'(2'b00));
        tick(); reset = 1'b0; idle(); settle();
        chk("rst_mid_nowen", 64'(ram_wen), 64'(1'b0));
        tick(); reset = 1'b1; idle(); settle();
        chk("rst_mid_ready", 64'({acl_ready, ram_wen}), 64'(2'b10));
        tick(); idle(); cpu_req = 1'b1; cpu_addr = 12'hFFF;
        tick(); idle(); settle();
        chk("rst_mid_status", 64'(cpu_q), 64'(32'h0));

        // back-to-back samples, 65 of them, ending in overflow
        for (int i = 0; i < 65; i++) begin
            tick(); idle(); acl_valid = 1'b1; acl_data = 15'(i + 1);
            settle();
            chk("b2b_accept", 64'({ram_wen, acl_ready}), 64'(2'b01));
            tick(); settle();
            chk("b2b_write", 64'({ram_wen, ram_addr, ram_din}),
                64'({1'b1, 12'hF00 + 12'(i % 64), 32'(i + 1)}));
        end
        tick(); idle(); cpu_req = 1'b1; cpu_addr = 12'hFFF;
        tick(); idle(); settle();
        chk("sts_overflow", 64'(cpu_q), 64'(32'h80400001));
        tick(); idle(); cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'hFFE;
        tick(); idle(); cpu_req = 1'b1; cpu_addr = 12'hFFF;
        tick(); idle(); settle();
        chk("sts_cleared", 64'(cpu_q), 64'(32'h00000001));

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
